// File: rtl/armleocpu_branch_ctrl_pkg.sv
// Shared encodings for the control-transfer sequencing controller.
package armleocpu_branch_ctrl_pkg;

  // Command type encodings from decode; 2'b11 is reserved and raises illegal instruction.
  localparam logic [1:0] CMD_BRANCH = 2'b00;
  localparam logic [1:0] CMD_JAL    = 2'b01;
  localparam logic [1:0] CMD_JALR   = 2'b10;

  // mcause codes reported on the response path.
  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StRedirect,
    StResp
  } state_t;

endpackage

// File: rtl/armleocpu_brcond.sv
// Branch condition unit: decodes funct3 and compares the two operands.
module armleocpu_brcond (
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken,
  output logic        incorrect_instruction
);

  // Condition decode; funct3 010/011 are not branch encodings.
  always_comb begin
    taken                 = 1'b0;
    incorrect_instruction = 1'b0;
    unique case (funct3)
      3'b000:  taken = (rs1 == rs2);
      3'b001:  taken = (rs1 != rs2);
      3'b100:  taken = ($signed(rs1) < $signed(rs2));
      3'b101:  taken = ($signed(rs1) >= $signed(rs2));
      3'b110:  taken = (rs1 < rs2);
      3'b111:  taken = (rs1 >= rs2);
      default: incorrect_instruction = 1'b1;
    endcase
  end

endmodule

// File: rtl/armleocpu_branch_ctrl.sv
// Execute-stage sequencer for BRANCH/JAL/JALR: latch, evaluate, redirect fetch, respond.
module armleocpu_branch_ctrl
  import armleocpu_branch_ctrl_pkg::*;
#(
  parameter logic C_EXT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [2:0]  cmd_funct3,
  input  logic [31:0] cmd_pc,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  input  logic [31:0] cmd_imm,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        resp_valid,
  output logic        resp_taken,
  output logic        resp_rd_write,
  output logic [31:0] resp_rd_wdata,
  output logic        resp_exc,
  output logic [3:0]  resp_cause
);

  state_t      state;
  logic [1:0]  type_q;
  logic [2:0]  funct3_q;
  logic [31:0] pc_q, rs1_q, rs2_q, imm_q;
  logic        taken_q, rd_write_q, exc_q;
  logic [31:0] rd_wdata_q, redirect_pc_q;
  logic [3:0]  cause_q;

  logic        br_taken, br_illegal;
  logic        taken, illegal, misaligned;
  logic [31:0] target, link;

  armleocpu_brcond u_brcond (
    .funct3                (funct3_q),
    .rs1                   (rs1_q),
    .rs2                   (rs2_q),
    .taken                 (br_taken),
    .incorrect_instruction (br_illegal)
  );

  // Evaluation of the latched command; only consumed while in StEval.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (type_q)
      CMD_BRANCH: begin
        taken   = br_taken;
        illegal = br_illegal;
      end
      CMD_JAL, CMD_JALR: taken = 1'b1;
      default: illegal = 1'b1;
    endcase
    target     = (type_q == CMD_JALR) ? ((rs1_q + imm_q) & ~32'h1) : (pc_q + imm_q);
    link       = pc_q + 32'd4;
    misaligned = taken & (C_EXT ? target[0] : |target[1:0]);
  end

  // Control FSM; every return to idle clears latched operands and response fields.
  always_ff @(posedge clk) begin
    if (rst || ((state != StIdle) && (flush || (state == StResp)))) begin
      state         <= StIdle;
      type_q        <= '0;
      funct3_q      <= '0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      taken_q       <= 1'b0;
      rd_write_q    <= 1'b0;
      rd_wdata_q    <= '0;
      exc_q         <= 1'b0;
      cause_q       <= '0;
      redirect_pc_q <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            type_q   <= cmd_type;
            funct3_q <= cmd_funct3;
            pc_q     <= cmd_pc;
            rs1_q    <= cmd_rs1;
            rs2_q    <= cmd_rs2;
            imm_q    <= cmd_imm;
            state    <= StEval;
          end
        end
        StEval: begin
          state <= StResp;
          // Illegal outranks misaligned; a faulting transfer never redirects or writes rd.
          if (illegal) begin
            exc_q   <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
          end else if (misaligned) begin
            exc_q   <= 1'b1;
            cause_q <= CAUSE_INSTR_MISALIGNED;
          end else if (taken) begin
            state         <= StRedirect;
            taken_q       <= 1'b1;
            rd_write_q    <= (type_q != CMD_BRANCH);
            rd_wdata_q    <= (type_q != CMD_BRANCH) ? link : '0;
            redirect_pc_q <= target;
          end
        end
        StRedirect: begin
          if (redirect_ready) state <= StResp;
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign cmd_ready      = (state == StIdle);
  assign redirect_valid = (state == StRedirect) & ~flush;
  assign redirect_pc    = redirect_pc_q;
  assign resp_valid     = (state == StResp) & ~flush;
  assign resp_taken     = taken_q;
  assign resp_rd_write  = rd_write_q;
  assign resp_rd_wdata  = rd_wdata_q;
  assign resp_exc       = exc_q;
  assign resp_cause     = cause_q;

endmodule

// File: tb/tb_armleocpu_branch_ctrl.sv
// Scoreboard bench: two controllers (C_EXT=0 and C_EXT=1) share stimulus.
module tb_armleocpu_branch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, cmd_valid, redirect_ready;
  logic [1:0]  cmd_type;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_pc, cmd_rs1, cmd_rs2, cmd_imm;

  logic        cmd_ready [2];
  logic        redirect_valid [2];
  logic [31:0] redirect_pc [2];
  logic        resp_valid [2];
  logic        resp_taken [2];
  logic        resp_rd_write [2];
  logic [31:0] resp_rd_wdata [2];
  logic        resp_exc [2];
  logic [3:0]  resp_cause [2];

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    armleocpu_branch_ctrl #(.C_EXT(g == 1)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready[g]),
      .cmd_type       (cmd_type),
      .cmd_funct3     (cmd_funct3),
      .cmd_pc         (cmd_pc),
      .cmd_rs1        (cmd_rs1),
      .cmd_rs2        (cmd_rs2),
      .cmd_imm        (cmd_imm),
      .redirect_valid (redirect_valid[g]),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc[g]),
      .resp_valid     (resp_valid[g]),
      .resp_taken     (resp_taken[g]),
      .resp_rd_write  (resp_rd_write[g]),
      .resp_rd_wdata  (resp_rd_wdata[g]),
      .resp_exc       (resp_exc[g]),
      .resp_cause     (resp_cause[g])
    );
  end

  // One expected transaction: cycle windows are absolute cycle numbers.
  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    int unsigned start, hs, resp, kill, idle;
    logic        taken, rdw, exc;
    logic [31:0] wdata;
    logic [3:0]  cause;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
    end
  endtask

  // Architectural reference for one control-transfer instruction.
  task automatic model(input logic [1:0] t, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input bit cext, output exp_t e);
    bit cond, ill, tk, mis;
    logic [31:0] tgt;
    cond = 1'b0;
    case (f3)
      3'd0: cond = (rs1 == rs2);
      3'd1: cond = (rs1 != rs2);
      3'd4: cond = ($signed(rs1) < $signed(rs2));
      3'd5: cond = ($signed(rs1) >= $signed(rs2));
      3'd6: cond = (rs1 < rs2);
      3'd7: cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
    ill = (t == 2'd3) || (t == 2'd0 && (f3 == 3'd2 || f3 == 3'd3));
    tk  = (t == 2'd0) ? cond : 1'b1;
    tgt = (t == 2'd2) ? ((rs1 + imm) & ~32'h1) : (pc + imm);
    mis = tk && (cext ? tgt[0] : (tgt[1:0] != 2'b00));
    e.redir = 1'b0; e.rpc = '0; e.taken = 1'b0; e.rdw = 1'b0; e.wdata = '0;
    e.exc = 1'b0; e.cause = '0;
    if (ill) begin
      e.exc = 1'b1; e.cause = 4'd2;
    end else if (mis) begin
      e.exc = 1'b1; e.cause = 4'd0;
    end else if (tk) begin
      e.redir = 1'b1; e.rpc = tgt; e.taken = 1'b1;
      e.rdw = (t != 2'd0); e.wdata = pc + 32'd4;
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    logic erv, esv;
    if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      total++;
      if (redirect_valid[i] !== 1'b0 || resp_valid[i] !== 1'b0) begin
        bad++;
        $display("FAIL stray_out dut%0d cyc=%0d redirect_valid=%b resp_valid=%b want 0 0",
                 i, cyc, redirect_valid[i], resp_valid[i]);
      end
      return;
    end
    if (i == 0) e = q0[0];
    else e = q1[0];
    erv = e.redir && cyc >= e.start && cyc <= e.hs && cyc < e.kill;
    esv = (cyc == e.resp) && (cyc < e.kill);
    chk(i, "redirect_valid", 32'(redirect_valid[i]), 32'(erv));
    if (erv) chk(i, "redirect_pc", redirect_pc[i], e.rpc);
    chk(i, "resp_valid", 32'(resp_valid[i]), 32'(esv));
    if (esv) begin
      chk(i, "resp_exc", 32'(resp_exc[i]), 32'(e.exc));
      chk(i, "resp_rd_write", 32'(resp_rd_write[i]), 32'(e.rdw));
      if (e.exc) chk(i, "resp_cause", 32'(resp_cause[i]), 32'(e.cause));
      else chk(i, "resp_taken", 32'(resp_taken[i]), 32'(e.taken));
      if (e.rdw) chk(i, "resp_rd_wdata", resp_rd_wdata[i], e.wdata);
    end
    if (cyc == e.idle) begin
      chk(i, "cmd_ready_after", 32'(cmd_ready[i]), 32'd1);
      if (i == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0);
      mon(1);
    end
  end

  // kind: 0 plain, 1 flush at rel cycle f, 2 rst at rel cycle f, 3 flush during accept.
  task automatic run_cmd(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input int hold, input int kind, input int f);
    exp_t e;
    int unsigned a;
    int rel;
    a = cyc;
    for (int i = 0; i < 2; i++) begin
      model(t, f3, pc, rs1, rs2, imm, (i == 1), e);
      e.start = a + 2;
      e.hs    = a + 2 + hold;
      e.resp  = e.redir ? a + 3 + hold : a + 2;
      e.kill  = 32'hFFFF_FFFF;
      e.idle  = e.resp + 1;
      if (kind == 1) begin
        e.kill = a + f;
        if (e.kill <= e.resp) e.idle = e.kill + 1;
      end else if (kind == 2) begin
        e.kill = a + f + 1;
        if (e.kill <= e.resp) e.idle = e.kill;
      end
      chk(i, "cmd_ready_accept", 32'(cmd_ready[i]), 32'd1);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    cmd_valid = 1'b1; cmd_type = t; cmd_funct3 = f3;
    cmd_pc = pc; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    flush = (kind == 3);
    @(posedge clk); #1;
    cmd_valid = 1'b0; flush = 1'b0;
    cmd_pc = $urandom; cmd_rs1 = $urandom; cmd_rs2 = $urandom; cmd_imm = $urandom;
    rel = 1;
    while (rel < 64 && (q0.size() != 0 || q1.size() != 0)) begin
      redirect_ready = (rel >= 2 + hold);
      flush = (kind == 1 && rel == f);
      rst   = (kind == 2 && rel == f);
      @(posedge clk); #1;
      rel++;
    end
    flush = 1'b0; rst = 1'b0; redirect_ready = 1'b0;
    total++;
    if (rel >= 64) begin
      bad++;
      $display("FAIL timeout cyc=%0d pending=%0d/%0d want 0/0", cyc, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    logic [1:0]  t;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    int hold, kind, f;
    rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; redirect_ready = 1'b0;
    cmd_type = '0; cmd_funct3 = '0; cmd_pc = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_cmd_ready", 32'(cmd_ready[i]), 32'd1);
      chk(i, "rst_redirect_valid", 32'(redirect_valid[i]), 32'd0);
      chk(i, "rst_redirect_pc", redirect_pc[i], 32'd0);
      chk(i, "rst_resp_valid", 32'(resp_valid[i]), 32'd0);
      chk(i, "rst_resp_exc", 32'(resp_exc[i]), 32'd0);
      chk(i, "rst_resp_rd_write", 32'(resp_rd_write[i]), 32'd0);
    end
    mon_on = 1'b1;

    run_cmd(2'd0, 3'd0, 32'h100, 32'h5, 32'h5, 32'h20, 0, 0, 0);            // BEQ taken
    run_cmd(2'd0, 3'd6, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 0, 0, 0);    // BLTU not taken
    run_cmd(2'd0, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40, 0, 0, 0);    // BLT taken
    run_cmd(2'd2, 3'd0, 32'h300, 32'h1003, 32'h0, 32'h0, 0, 0, 0);          // JALR odd target
    run_cmd(2'd0, 3'd2, 32'h300, 32'h1, 32'h1, 32'h8, 0, 0, 0);             // bad funct3
    run_cmd(2'd3, 3'd0, 32'h300, 32'h1, 32'h1, 32'h8, 0, 0, 0);             // reserved type
    run_cmd(2'd1, 3'd0, 32'h400, 32'h0, 32'h0, 32'h80, 5, 0, 0);            // JAL, fetch stalls
    run_cmd(2'd1, 3'd0, 32'h100, 32'h0, 32'h0, 32'h2, 0, 0, 0);             // JAL halfword target
    run_cmd(2'd1, 3'd0, 32'h500, 32'h0, 32'h0, 32'h10, 2, 1, 4);            // flush with handshake
    run_cmd(2'd1, 3'd0, 32'h500, 32'h0, 32'h0, 32'h10, 0, 1, 1);            // flush in EVAL
    run_cmd(2'd1, 3'd0, 32'h500, 32'h0, 32'h0, 32'h10, 2, 2, 3);            // rst in REDIRECT
    run_cmd(2'd1, 3'd0, 32'h500, 32'h0, 32'h0, 32'h10, 0, 2, 1);            // rst in EVAL
    run_cmd(2'd0, 3'd1, 32'h600, 32'h7, 32'h8, 32'hFFFF_FFF0, 0, 3, 0);     // flush in IDLE

    for (int n = 0; n < 200; n++) begin
      t    = 2'($urandom_range(0, 3));
      f3   = 3'($urandom_range(0, 7));
      pc   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      rs1  = $urandom;
      rs2  = ($urandom_range(0, 2) == 0) ? rs1 : $urandom;
      imm  = $urandom;
      imm[31:12] = {20{imm[11]}};
      hold = $urandom_range(0, 3);
      kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      f    = $urandom_range(1, 3 + hold);
      run_cmd(t, f3, pc, rs1, rs2, imm, hold, kind, f);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/armleocpu_branch_ctrl.md
Name: armleocpu_branch_ctrl

Overview:
- Sequencing controller for control-transfer instructions in the execute stage.
- Accepts one BRANCH/JAL/JALR command from decode and latches operands.
- Evaluates the condition through an internal instance of the branch condition unit, computes target and link value, and checks target alignment.
- Issues a redirect to fetch over a valid/ready handshake and reports completion or an exception to the writeback path.

Parameters:
- C_EXT, 0: 1 = compressed extension present; misalignment checks target[0] only. 0 = checks target[1:0].

Ports:
- clk  in  1  clock, all state on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  abort the in-flight command (trap/interrupt); highest priority
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept
- cmd_type  in  2  00 BRANCH, 01 JAL, 10 JALR, 11 reserved
- cmd_funct3  in  3  branch funct3
- cmd_pc  in  32  instruction PC
- cmd_rs1  in  32  operand 1
- cmd_rs2  in  32  operand 2
- cmd_imm  in  32  sign-extended immediate
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  32  new PC
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_taken  out  1  control transfer occurred
- resp_rd_write  out  1  link writeback required
- resp_rd_wdata  out  32  link value
- resp_exc  out  1  exception
- resp_cause  out  4  mcause code: 0 = instr addr misaligned, 2 = illegal instruction

Behaviour:
- FSM states: IDLE, EVAL, REDIRECT, RESP. All outputs are registered or decoded from state/latched registers only; there is no combinational path from cmd_* to outputs.
- Reset (rst=1 at an edge, any state) forces IDLE. In IDLE, all resp_* and redirect_* outputs are 0, cmd_ready=1, and latched operands are 0.
- Reset mid-redirect drops redirect_valid the next cycle with no resp.
- cmd_ready=1 only in IDLE. cmd_valid&cmd_ready latches type/funct3/pc/rs1/rs2/imm, then goes to EVAL.
- EVAL (exactly one cycle) works on the latched values:
  - The brcond instance evaluates funct3/rs1/rs2.
  - BRANCH: taken = brcond taken; illegal = brcond incorrect_instruction.
  - JAL and JALR: taken = 1.
  - type 11: illegal.
  - Target: BRANCH/JAL = pc+imm; JALR = (rs1+imm) & ~1. Arithmetic is 32-bit modulo, wrap-around ignored.
  - Link value = pc+4 (modulo 2^32).
  - misaligned = taken & (C_EXT ? target[0] : |target[1:0]).
- EVAL next state and response fields:
  - illegal → RESP, exc=1, cause=2.
  - misaligned → RESP, exc=1, cause=0, no redirect.
  - taken → REDIRECT.
  - otherwise → RESP, taken=0.
  - Illegal takes priority over misaligned.
- REDIRECT holds redirect_valid=1 and redirect_pc stable until redirect_ready. On the handshake cycle, go to RESP with taken=1, rd_write = (JAL|JALR), rd_wdata = link. Exceptions never write rd.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency:
  - Not-taken/exception: accept in cycle N, resp_valid in N+2.
  - Taken with redirect_ready already high: redirect_valid in N+2, resp_valid in N+3.
- flush in EVAL, REDIRECT or RESP → IDLE next cycle. resp_valid and redirect_valid are suppressed from that cycle on (decoded with ~flush).
- flush in the same cycle as redirect_ready: flush wins and the redirect is considered not issued.
- flush in IDLE: the command is still accepted if cmd_valid is high.
- Back-to-back commands: the next command is accepted earliest the cycle after RESP.

Decomposition:
- Shared package/defines header holds:
  - cmd_type encodings (BRANCH/JAL/JALR);
  - cause codes (CAUSE_INSTR_MISALIGNED=0, CAUSE_ILLEGAL=2);
  - FSM state encoding.
- One sub-module: armleocpu_brcond (existing condition unit), instantiated once on the latched funct3/rs1/rs2. Target/link adders stay inline.

Test Plan:
- BEQ: rs1=rs2=0x5, pc=0x100, imm=0x20 → redirect_pc=0x120 at N+2; resp taken=1, rd_write=0, exc=0.
- BLTU with rs1=0xFFFFFFFF, rs2=1 → not taken, resp_valid at N+2, no redirect. BLT with the same operands → taken.
- JALR: rs1=0x1003, imm=0, C_EXT=0 → target 0x1002; resp exc=1, cause=0, no redirect.
  - Same case with C_EXT=1 → redirect_pc=0x1002, rd_wdata=pc+4.
- BRANCH funct3=3'b010 or cmd_type=11 → resp exc=1, cause=2, redirect_valid never asserted.
- JAL with redirect_ready held low 5 cycles → redirect_valid and redirect_pc stable for 5 cycles; resp one cycle after the handshake, rd_wdata=pc+4.
- flush asserted in REDIRECT together with redirect_ready, and separately in EVAL → no resp_valid, IDLE next cycle, cmd_ready=1. Repeat with rst instead of flush → same outcome.
